vram_fetch_pipe: RTL and testbench

- Sits between the VGA timing generator and the text-mode colour mapper. Converts the raw DrawX/DrawY pixel coordinate into a VRAM word address and drives the BRAM read port.
- Delays the pixel coordinate and sync/blank signals so they arrive at the colour mapper aligned with the returned VRAM word.
- Holds a frame-stable copy of the control (colour) register and a frame counter.

---
 rtl/vram_fetch_pipe.sv | 134 +++++++++++++
 tb/tb_vram_fetch_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_pipe.sv
// VRAM fetch pipeline: pixel coordinate to text-mode VRAM word address,
// with sync/coordinate delay line aligned to BRAM read data.
module vram_fetch_pipe #(
  parameter int READ_LAT   = 1,
  parameter int COLS_WORDS = 20,
  parameter int H_VIS      = 640,
  parameter int V_VIS      = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX_in,
  input  logic [9:0]  DrawY_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        vde_in,
  input  logic [31:0] ctrl_in,
  output logic [10:0] bram_addr,
  output logic        bram_en,
  input  logic [31:0] bram_rdata,
  output logic [9:0]  DrawX_out,
  output logic [9:0]  DrawY_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        vde_out,
  output logic [31:0] word_out,
  output logic [31:0] ctrl_out,
  output logic [7:0]  frame_cnt
);

  localparam int PIPE = 1 + READ_LAT;

  logic          w_vis;
  logic [5:0]    w_row;
  logic [4:0]    w_col;
  logic [10:0]   w_addr;
  logic          w_vs_fall;

  logic [10:0]         r_addr;
  logic [READ_LAT-1:0] r_en_sr;
  logic [31:0]         r_word;
  logic [9:0]          r_x   [PIPE];
  logic [9:0]          r_y   [PIPE];
  logic                r_hs  [PIPE];
  logic                r_vs  [PIPE];
  logic                r_vde [PIPE];
  logic                r_vs_prev;
  logic [31:0]         r_ctrl;
  logic [7:0]          r_frame;

  assign w_vis = (DrawX_in < 10'(H_VIS))
              && (DrawY_in < 10'(V_VIS));
  assign w_row = DrawY_in[9:4];
  assign w_col = DrawX_in[9:5];
  // 11-bit product keeps row 29 (29*20+19 = 599) intact
  assign w_addr = 11'(w_row) * 11'(COLS_WORDS)
                + 11'(w_col);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr  <= '0;
      r_en_sr <= '0;
    end else begin
      r_addr  <= w_vis ? w_addr : '0;
      r_en_sr <= (r_en_sr << 1)
               | READ_LAT'(w_vis);
    end
  end

  assign bram_addr = r_addr;
  assign bram_en   = r_en_sr[0];

  // enable tap lines up with the cycle bram_rdata is valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_word <= '0;
    end else begin
      r_word <= r_en_sr[READ_LAT-1]
              ? bram_rdata : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PIPE; i++) begin
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_hs[i]  <= 1'b1;
        r_vs[i]  <= 1'b1;
        r_vde[i] <= 1'b0;
      end
    end else begin
      r_x[0]   <= DrawX_in;
      r_y[0]   <= DrawY_in;
      r_hs[0]  <= hs_in;
      r_vs[0]  <= vs_in;
      r_vde[0] <= vde_in;
      for (int i = 1; i < PIPE; i++) begin
        r_x[i]   <= r_x[i-1];
        r_y[i]   <= r_y[i-1];
        r_hs[i]  <= r_hs[i-1];
        r_vs[i]  <= r_vs[i-1];
        r_vde[i] <= r_vde[i-1];
      end
    end
  end

  assign DrawX_out = r_x[PIPE-1];
  assign DrawY_out = r_y[PIPE-1];
  assign hs_out    = r_hs[PIPE-1];
  assign vs_out    = r_vs[PIPE-1];
  assign vde_out   = r_vde[PIPE-1];
  assign word_out  = r_word;

  // prev resets high so leaving reset never looks like a vsync edge
  assign w_vs_fall = r_vs_prev & ~r_vs[PIPE-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vs_prev <= 1'b1;
      r_ctrl    <= '0;
      r_frame   <= '0;
    end else begin
      r_vs_prev <= r_vs[PIPE-1];
      if (w_vs_fall) begin
        r_ctrl  <= ctrl_in;
        r_frame <= r_frame + 8'd1;
      end
    end
  end

  assign ctrl_out  = r_ctrl;
  assign frame_cnt = r_frame;

endmodule

// File: tb/tb_vram_fetch_pipe.sv
// Scoreboard bench for vram_fetch_pipe at READ_LAT=1 and READ_LAT=2,
// driven with standard 800x525 VGA timing.
module tb_vram_fetch_pipe;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        vde;
    logic [31:0] w;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX_in;
  logic [9:0]  DrawY_in;
  logic        hs_in;
  logic        vs_in;
  logic        vde_in;
  logic [31:0] ctrl_in;

  logic [10:0] addr0, addr1;
  logic        en0, en1;
  logic [31:0] rd0, rd1;
  logic [9:0]  xo0, xo1, yo0, yo1;
  logic        hso0, hso1, vso0, vso1;
  logic        vdeo0, vdeo1;
  logic [31:0] wo0, wo1, co0, co1;
  logic [7:0]  fc0, fc1;

  int n_pass;
  int n_total;

  exp_t q0[$];
  exp_t q1[$];

  int          pipe_d  [2];
  logic        m_prev  [2];
  logic        m_vs    [2];
  logic [31:0] m_ctrl  [2];
  logic [7:0]  m_frame [2];

  vram_fetch_pipe #(.READ_LAT(1)) u_dut0 (
    .Clk(Clk), .Reset(Reset),
    .DrawX_in(DrawX_in), .DrawY_in(DrawY_in),
    .hs_in(hs_in), .vs_in(vs_in), .vde_in(vde_in),
    .ctrl_in(ctrl_in),
    .bram_addr(addr0), .bram_en(en0),
    .bram_rdata(rd0),
    .DrawX_out(xo0), .DrawY_out(yo0),
    .hs_out(hso0), .vs_out(vso0), .vde_out(vdeo0),
    .word_out(wo0), .ctrl_out(co0), .frame_cnt(fc0)
  );

  vram_fetch_pipe #(.READ_LAT(2)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .DrawX_in(DrawX_in), .DrawY_in(DrawY_in),
    .hs_in(hs_in), .vs_in(vs_in), .vde_in(vde_in),
    .ctrl_in(ctrl_in),
    .bram_addr(addr1), .bram_en(en1),
    .bram_rdata(rd1),
    .DrawX_out(xo1), .DrawY_out(yo1),
    .hs_out(hso1), .vs_out(vso1), .vde_out(vdeo1),
    .word_out(wo1), .ctrl_out(co1), .frame_cnt(fc1)
  );

  function automatic logic [31:0] mem(input logic [10:0] a);
    return (a == 11'd43) ? 32'hA5A5_0043 : {21'd0, a};
  endfunction

  // latency 1: data valid the cycle after the address register
  always_comb rd0 = mem(addr0);
  // latency 2: one extra output register
  always @(posedge Clk) rd1 <= mem(addr1);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int d,
                     input logic [63:0] o,
                     input logic [63:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s dut%0d observed=%h expected=%h",
                tag, d, o, e);
  endtask

  function automatic exp_t obs(input int d);
    exp_t o;
    if (d == 0) begin
      o.x = xo0; o.y = yo0; o.hs = hso0;
      o.vs = vso0; o.vde = vdeo0; o.w = wo0;
    end else begin
      o.x = xo1; o.y = yo1; o.hs = hso1;
      o.vs = vso1; o.vde = vdeo1; o.w = wo1;
    end
    return o;
  endfunction

  task automatic step(input int x, input int y);
    exp_t        e;
    exp_t        p;
    exp_t        r;
    logic        vis;
    logic [10:0] a;
    int          qs;
    DrawX_in = 10'(x);
    DrawY_in = 10'(y);
    hs_in    = !(x >= 656 && x < 752);
    vs_in    = !(y >= 490 && y < 492);
    vis      = (x < 640) && (y < 480);
    vde_in   = vis;
    a        = vis ? 11'((y / 16) * 20 + x / 32) : 11'd0;
    e.x = 10'(x); e.y = 10'(y);
    e.hs = hs_in; e.vs = vs_in; e.vde = vde_in;
    e.w = vis ? mem(a) : 32'd0;
    r.x = '0; r.y = '0; r.hs = 1'b1;
    r.vs = 1'b1; r.vde = 1'b0; r.w = '0;
    if (!Reset) begin
      q0.push_back(e);
      q1.push_back(e);
    end
    @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("bram_addr", d, 64'(d == 0 ? addr0 : addr1),
          64'(Reset ? 11'd0 : a));
      chk("bram_en", d, 64'(d == 0 ? en0 : en1),
          64'(vis && !Reset));
      if (Reset) begin
        q0.delete();
        q1.delete();
        m_prev[d]  = 1'b1;
        m_vs[d]    = 1'b1;
        m_ctrl[d]  = '0;
        m_frame[d] = '0;
        chk("reset_outs", d, 64'(obs(d)), 64'(r));
      end else begin
        if (m_prev[d] && !m_vs[d]) begin
          m_ctrl[d]  = ctrl_in;
          m_frame[d] = m_frame[d] + 8'd1;
        end
        m_prev[d] = m_vs[d];
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs >= pipe_d[d]) begin
          if (d == 0) p = q0.pop_front();
          else        p = q1.pop_front();
          m_vs[d] = p.vs;
          chk("pipe", d, 64'(obs(d)), 64'(p));
        end else begin
          m_vs[d] = 1'b1;
        end
      end
      chk("ctrl_out", d, 64'(d == 0 ? co0 : co1),
          64'(m_ctrl[d]));
      chk("frame_cnt", d, 64'(d == 0 ? fc0 : fc1),
          64'(m_frame[d]));
    end
    @(negedge Clk);
  endtask

  int rows[12] = '{0, 15, 16, 200, 464, 479,
                   480, 489, 490, 491, 492, 524};

  initial begin
    n_pass    = 0;
    n_total   = 0;
    pipe_d[0] = 2;
    pipe_d[1] = 3;
    Reset     = 1'b1;
    ctrl_in   = 32'h0;

    repeat (3) step(0, 0);
    Reset = 1'b0;
    step(0, 0);
    step(100, 40);
    step(639, 479);
    step(640, 479);
    repeat (3) step(641, 479);

    for (int x = 290; x < 300; x++) step(x, 100);
    Reset = 1'b1;
    step(300, 100);
    step(301, 100);
    Reset = 1'b0;
    for (int x = 302; x < 320; x++) step(x, 100);

    foreach (rows[i]) begin
      for (int x = 0; x < 800; x++) begin
        if (rows[i] == 200 && x == 400)
          ctrl_in = 32'h01E0_001E;
        step(x, rows[i]);
      end
    end

    chk("ctrl_final", 0, 64'(co0), 64'(32'h01E0_001E));
    chk("frame_final", 0, 64'(fc0), 64'(8'd1));
    chk("ctrl_final", 1, 64'(co1), 64'(32'h01E0_001E));
    chk("frame_final", 1, 64'(fc1), 64'(8'd1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
